// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;

  typedef enum logic [2:0] {
    ST_HDR_HI,
    ST_HDR_LO,
    ST_DATA,
    ST_CSUM,
    ST_HOLD,
    ST_RUN,
    ST_ERR
  } boot_state_e;

  localparam int unsigned COUNT_W   = 16;
  localparam logic [7:0]  CSUM_SEED = 8'h00;

endpackage

// File: rtl/boot_word_packer.sv
// Packs a byte stream big-endian into 32-bit words; word/word_valid are registered
// and word_valid pulses for one cycle on the edge that accepts the 4th byte.
module boot_word_packer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_idx,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] partial;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      partial    <= '0;
      byte_idx   <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        if (byte_idx == 2'd3) begin
          word       <= {partial, byte_data};
          word_valid <= 1'b1;
        end else begin
          partial <= {partial[15:0], byte_data};
        end
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads instruction memory from a host byte stream, then releases cpu_rst.
// Optional trailing XOR checksum byte enabled by defining IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int unsigned CAPACITY = 2 ** ADDR_W;
  localparam int unsigned HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam boot_state_e POST_PAYLOAD = ST_CSUM;
`else
  localparam boot_state_e POST_PAYLOAD = ST_HOLD;
`endif

  boot_state_e         state, state_nx;
  logic [7:0]          hdr_hi;
  logic [COUNT_W-1:0]  n_words;
  logic [COUNT_W-1:0]  wcnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [COUNT_W-1:0]  hdr_count;
  logic                last_word;
  logic [1:0]          pk_idx;
  logic                pk_valid;
  logic [31:0]         pk_word;

  assign hdr_count = {hdr_hi, rx_data};
  assign last_word = (wcnt == n_words - COUNT_W'(1));

  boot_word_packer u_packer (
    .CLK        (CLK),
    .RST        (RST),
    .byte_valid (rx_valid && (state == ST_DATA)),
    .byte_data  (rx_data),
    .byte_idx   (pk_idx),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  assign wr_en   = pk_valid;
  assign wr_data = pk_word;

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      csum <= CSUM_SEED;
    else if (rx_valid && (state == ST_DATA))
      csum <= csum ^ rx_data;
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_HDR_HI;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rx_ready = 1'b0;
    cpu_rst  = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      ST_HDR_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nx = ST_HDR_LO;
      end
      ST_HDR_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if ({16'd0, hdr_count} > CAPACITY) state_nx = ST_ERR;
          else if (hdr_count == '0)          state_nx = POST_PAYLOAD;
          else                               state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && (pk_idx == 2'd3) && last_word) state_nx = POST_PAYLOAD;
      end
      ST_CSUM: begin
        rx_ready = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
        if (rx_valid) state_nx = (rx_data == csum) ? ST_HOLD : ST_ERR;
`endif
      end
      ST_HOLD: begin
        if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) state_nx = ST_RUN;
      end
      ST_RUN: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      ST_ERR: begin
        err = 1'b1;
      end
      default: state_nx = ST_HDR_HI;
    endcase
  end

  // wr_addr is captured alongside the packer's registered word so all three
  // write-port signals change on the same edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hdr_hi   <= '0;
      n_words  <= '0;
      wcnt     <= '0;
      hold_cnt <= '0;
      wr_addr  <= '0;
    end else begin
      if (rx_valid && (state == ST_HDR_HI))
        hdr_hi <= rx_data;
      if (rx_valid && (state == ST_HDR_LO)) begin
        n_words <= hdr_count;
        wcnt    <= '0;
      end
      if (rx_valid && (state == ST_DATA) && (pk_idx == 2'd3)) begin
        wr_addr <= wcnt[ADDR_W-1:0];
        wcnt    <= wcnt + COUNT_W'(1);
      end
      if (state == ST_HOLD)
        hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader (ADDR_W=8, HOLD_CYCLES=4).
module tb_imem_boot_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  int base;
  int img_len;
  logic [7:0] img [0:10];

  imem_boot_loader #(.ADDR_W(8), .HOLD_CYCLES(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK)
    if (wr_en === 1'b1) wr_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    RST = 1'b1;
    #2;
    RST = 1'b0;
  endtask

  task automatic hold_to_run(input string tag);
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00);
    check({tag, "_rst_before"}, cpu_rst, 1);
    check({tag, "_done_before"}, done, 0);
    step(1'b0, 8'h00);
    check({tag, "_rst_after"}, cpu_rst, 0);
    check({tag, "_done_after"}, done, 1);
  endtask

  initial begin
    img = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h10, 8'h8D, 8'h09, 8'h00, 8'h00, 8'hA0};
`ifdef IMEM_BOOT_CHECKSUM_EN
    img_len = 11;
`else
    img_len = 10;
`endif

    // Reset values
    do_reset();
    check("rst_ready", rx_ready, 1);
    check("rst_wren", wr_en, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    check("rst_cpurst", cpu_rst, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    // Back-to-back load
    base = wr_count;
    for (int i = 0; i < img_len; i++) begin
      step(1'b1, img[i]);
      if (i == 5) begin
        check("bb_w0_en", wr_en, 1);
        check("bb_w0_addr", wr_addr, 0);
        check("bb_w0_data", wr_data, 32'h3C080010);
      end
      if (i == 6) check("bb_w0_pulse", wr_en, 0);
      if (i == 9) begin
        check("bb_w1_en", wr_en, 1);
        check("bb_w1_addr", wr_addr, 1);
        check("bb_w1_data", wr_data, 32'h8D090000);
      end
    end
    check("bb_hold_ready", rx_ready, 0);
    hold_to_run("bb");
    check("bb_writes", wr_count - base, 2);

    // Extra bytes in RUN are ignored
    for (int k = 0; k < 3; k++) step(1'b1, 8'hAA);
    check("run_ready", rx_ready, 0);
    check("run_writes", wr_count - base, 2);
    check("run_done", done, 1);

    // Load with rx_valid toggling
    do_reset();
    base = wr_count;
    for (int i = 0; i < img_len; i++) begin
      step(1'b1, img[i]);
      if (i == 5) begin
        check("gap_w0_en", wr_en, 1);
        check("gap_w0_addr", wr_addr, 0);
        check("gap_w0_data", wr_data, 32'h3C080010);
      end
      if (i == 9) begin
        check("gap_w1_en", wr_en, 1);
        check("gap_w1_addr", wr_addr, 1);
        check("gap_w1_data", wr_data, 32'h8D090000);
      end
      if (i != img_len - 1) begin
        step(1'b0, 8'hFF);
        if (i == 5) check("gap_w0_pulse", wr_en, 0);
        if (i == 4) check("gap_stall_noword", wr_en, 0);
      end
    end
    hold_to_run("gap");
    check("gap_writes", wr_count - base, 2);

    // Oversized header count 0x0101
    do_reset();
    base = wr_count;
    step(1'b1, 8'h01);
    check("big_nerr_hi", err, 0);
    step(1'b1, 8'h01);
    check("big_err", err, 1);
    check("big_cpurst", cpu_rst, 1);
    check("big_done", done, 0);
    check("big_ready", rx_ready, 0);
    for (int k = 0; k < 4; k++) step(1'b1, 8'h3C);
    check("big_sticky", err, 1);
    check("big_writes", wr_count - base, 0);

    // Count exactly 2**ADDR_W is legal
    do_reset();
    step(1'b1, 8'h01);
    step(1'b1, 8'h00);
    check("cap_err", err, 0);
    check("cap_ready", rx_ready, 1);

    // Zero-word image
    do_reset();
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
`ifdef IMEM_BOOT_CHECKSUM_EN
    check("zero_csum_ready", rx_ready, 1);
    step(1'b1, 8'h00);
`endif
    check("zero_hold_ready", rx_ready, 0);
    hold_to_run("zero");

    // RST mid-load, then full reload
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, img[i]);
    check("mid_w0_en", wr_en, 1);
    RST = 1'b1;
    #2;
    check("mid_ready", rx_ready, 1);
    check("mid_wren", wr_en, 0);
    check("mid_addr", wr_addr, 0);
    check("mid_data", wr_data, 0);
    check("mid_cpurst", cpu_rst, 1);
    check("mid_done", done, 0);
    check("mid_err", err, 0);
    RST = 1'b0;
    base = wr_count;
    for (int i = 0; i < img_len; i++) begin
      step(1'b1, img[i]);
      if (i == 5) begin
        check("rl_w0_addr", wr_addr, 0);
        check("rl_w0_data", wr_data, 32'h3C080010);
      end
      if (i == 9) check("rl_w1_addr", wr_addr, 1);
    end
    hold_to_run("rl");
    check("rl_writes", wr_count - base, 2);

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Checksum match: 12^34^56^78 = 08
    do_reset();
    step(1'b1, 8'h00);
    step(1'b1, 8'h01);
    step(1'b1, 8'h12);
    step(1'b1, 8'h34);
    step(1'b1, 8'h56);
    step(1'b1, 8'h78);
    check("cs_w_data", wr_data, 32'h12345678);
    check("cs_w_addr", wr_addr, 0);
    step(1'b1, 8'h08);
    check("cs_ok_err", err, 0);
    hold_to_run("cs_ok");

    // Checksum mismatch
    do_reset();
    step(1'b1, 8'h00);
    step(1'b1, 8'h01);
    step(1'b1, 8'h12);
    step(1'b1, 8'h34);
    step(1'b1, 8'h56);
    step(1'b1, 8'h78);
    step(1'b1, 8'h09);
    check("cs_bad_err", err, 1);
    check("cs_bad_cpurst", cpu_rst, 1);
    check("cs_bad_done", done, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
